lock_guard: RTL and testbench
=============================

# lock_guard

Attempt-limiting front end for the keypad lock. It sits between the keypad scanner and the code decider, and forwards each key as a one-cycle code/valid pulse. After every 5-key entry it watches the decider's verdict outputs and counts failed entries. Once the failure limit is reached it enters a timed lockout, during which all keys are swallowed and the alarm is raised.

## Interface
Parameters:
- MAX_FAIL, 3 — consecutive failed entries that trigger lockout; legal range 1..7.
- VERDICT_CYCLES, 4 — cycles after the 5th key in which a decider success flag is accepted; must be ≥1.
- LOCKOUT_CYCLES, 1000 — lockout duration in clk cycles; must be ≥1; counter width is $clog2(LOCKOUT_CYCLES+1).
- RELOCK_CYCLES, 5000 — OPEN hold limit; used only with the auto-relock feature.

Ports:
- clk  in  1  system clock. One clock domain only.
- reset_1  in  1  synchronous, active-low reset.
- key_code_in  in  4  scanned key code (#=1010, *=1011, digits 0000–1001).
- key_valid_in  in  1  key-held level from the scanner, synchronous to clk.
- dec_open  in  1  decider OPEN.
- dec_save  in  1  decider SAVE_LIGHT.
- dec_change  in  1  decider CHANGE.
- code_out  out  4  forwarded key code.
- valid_out  out  1  one-cycle forwarded key strobe.
- lockout  out  1  high while in LOCKOUT.
- alarm  out  1  high while in LOCKOUT.
- fail_cnt  out  3  current consecutive-failure count.
- relock_req  out  1  one-cycle request to force the decider back to LOCK.

## Operation
- **Key edge:** `key_edge = key_valid_in & ~key_valid_d`, where `key_valid_d` is a registered copy of `key_valid_in`.
  - Only rising edges count.
  - A key held across any state change is never forwarded again.
- **State machine** (one-hot): IDLE, COLLECT, VERDICT, LOCKOUT. There is also a 3-bit key index `kidx` with range 0..4.
- **IDLE:**
  - On key_edge: forward the key, set kidx=1, go to COLLECT.
- **COLLECT:**
  - On key_edge: forward the key and increment kidx.
  - On the key that makes kidx reach 5: clear kidx, load the verdict timer with VERDICT_CYCLES-1, go to VERDICT.
- **VERDICT:**
  - key_edge is dropped (not forwarded).
  - If any of dec_open, dec_save or dec_change is high in any window cycle: success. Set fail_cnt=0 and go to IDLE.
  - Otherwise, when the timer reaches 0: failure. Apply fail_cnt+1.
    - If the new value equals MAX_FAIL: go to LOCKOUT, load the lockout timer with LOCKOUT_CYCLES-1, and hold fail_cnt at MAX_FAIL.
    - Else: go to IDLE.
  - A success flag seen on the same cycle the timer expires counts as success.
- **LOCKOUT:**
  - key_edge is dropped, valid_out=0, lockout=alarm=1.
  - The timer decrements each cycle. When it reaches 0: fail_cnt=0, go to IDLE.
  - A key_edge on the exit cycle is dropped.
- **Forwarding:** code_out is loaded with key_code_in and valid_out pulses for exactly one cycle. code_out holds its value until the next forwarded key.
- **fail_cnt:** never exceeds MAX_FAIL and never wraps.
- **Reset values:** when reset_1=0 at a clk edge, all of the following are set regardless of current state, aborting any entry, verdict or lockout:
  - state=IDLE, kidx=0, both timers=0, key_valid_d=0.
  - code_out=0000, valid_out=0, lockout=0, alarm=0, fail_cnt=0, relock_req=0.

## Timing
- **Forwarding latency:** if key_valid_in is first sampled high at edge k, then code_out and valid_out are updated at edge k. valid_out is high for the single cycle between edges k and k+1.
- **Consecutive keys:** back-to-back keys need at least one low cycle of key_valid_in between them. The scanner guarantees this.
- **Verdict window:** covers edges k5+1 through k5+VERDICT_CYCLES, where k5 is the edge that forwarded the 5th key.
- **Lockout entry:** lockout rises at edge k5+VERDICT_CYCLES and stays high for LOCKOUT_CYCLES cycles.
- **Registered outputs:** state-derived outputs lockout and alarm are registered and change on the edge that enters or leaves LOCKOUT.

## Configuration
- **Macro:** LOCK_GUARD_AUTO_RELOCK_EN.
- **Defined:**
  - A hold counter increments while dec_open=1 and clears whenever dec_open=0.
  - When the count reaches RELOCK_CYCLES, relock_req pulses for one cycle and the counter clears.
  - If dec_open is still high, the cycle repeats every RELOCK_CYCLES cycles.
  - Operation in all states is unaffected.
- **Undefined:** the hold counter is not built and relock_req is tied to 0.

## Test plan
- **Pass-through:** press keys 2,4,3,2,# with dec_open pulsed 2 cycles after the 5th key → five one-cycle valid_out pulses with code_out = 2,4,3,2,1010; fail_cnt stays 0; lockout stays 0.
- **Lockout:** three 5-key entries with no dec_* response (MAX_FAIL=3, VERDICT_CYCLES=4) → fail_cnt goes 1, then 2; on the third expiry lockout=alarm=1 for exactly 1000 cycles, then fail_cnt=0 and state returns to IDLE.
- **Key swallowing:** keys during VERDICT and LOCKOUT, plus a key held across lockout exit → no valid_out pulses; the first new rising edge after exit is forwarded as key 1.
- **Reset abort:** reset_1 low for one cycle mid-lockout (timer at 500) → next cycle lockout=0, alarm=0, fail_cnt=0, code_out=0000; a following entry is forwarded normally.
- **Window boundaries:** dec_save high on the exact expiry cycle of the window → treated as success, fail_cnt=0; dec_save high one cycle after expiry → counted as a failure.
- **Auto-relock:** with LOCK_GUARD_AUTO_RELOCK_EN and RELOCK_CYCLES=10, hold dec_open high for 25 cycles → relock_req pulses at cycles 10 and 20. Without the macro, relock_req stays 0.

Source files
------------

// File: rtl/lock_guard.sv
// lock_guard: attempt-limiting front end between the keypad scanner and the
// code decider. It forwards each key press as a one-cycle code/valid pulse,
// judges every 5-key entry from the decider's verdict flags, and enters a
// timed lockout (keys swallowed, alarm raised) after MAX_FAIL consecutive
// failed entries.
//
// Optional feature: define LOCK_GUARD_AUTO_RELOCK_EN to build the OPEN hold
// counter that pulses relock_req every RELOCK_CYCLES cycles of dec_open.
// Without it relock_req is tied low.
module lock_guard #(
  parameter int MAX_FAIL       = 3,     // 1..7
  parameter int VERDICT_CYCLES = 4,     // >= 1
  parameter int LOCKOUT_CYCLES = 1000,  // >= 1
  parameter int RELOCK_CYCLES  = 5000   // auto-relock only
) (
  input  logic       clk,
  input  logic       reset_1,
  input  logic [3:0] key_code_in,
  input  logic       key_valid_in,
  input  logic       dec_open,
  input  logic       dec_save,
  input  logic       dec_change,
  output logic [3:0] code_out,
  output logic       valid_out,
  output logic       lockout,
  output logic       alarm,
  output logic [2:0] fail_cnt,
  output logic       relock_req
);

  localparam int VT_W = $clog2(VERDICT_CYCLES + 1);
  localparam int LT_W = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    COLLECT = 4'b0010,
    VERDICT = 4'b0100,
    LOCKOUT = 4'b1000
  } state_t;

  state_t          state;
  logic [2:0]      kidx;
  logic [VT_W-1:0] vtimer;
  logic [LT_W-1:0] ltimer;
  logic            key_valid_d;

  logic            key_edge;
  logic            dec_any;
  logic [2:0]      fail_next;

  // A key counts only on its rising edge, so a key held across any state
  // change can never be forwarded twice.
  assign key_edge  = key_valid_in & ~key_valid_d;
  assign dec_any   = dec_open | dec_save | dec_change;
  assign fail_next = fail_cnt + 3'd1;

  // Main controller: key forwarding, entry counting, verdict window, lockout.
  always_ff @(posedge clk) begin
    if (!reset_1) begin
      state       <= IDLE;
      kidx        <= 3'd0;
      vtimer      <= '0;
      ltimer      <= '0;
      key_valid_d <= 1'b0;
      code_out    <= 4'd0;
      valid_out   <= 1'b0;
      lockout     <= 1'b0;
      alarm       <= 1'b0;
      fail_cnt    <= 3'd0;
    end else begin
      // NOTE: every register here uses non-blocking assignment so all state
      // updates see the values from before this edge, independent of order.
      key_valid_d <= key_valid_in;
      // NOTE: valid_out is defaulted low each cycle and only raised on a
      // forwarded key, which is what makes it a single-cycle strobe.
      valid_out   <= 1'b0;

      unique case (state)
        IDLE: begin
          if (key_edge) begin
            code_out  <= key_code_in;
            valid_out <= 1'b1;
            kidx      <= 3'd1;
            state     <= COLLECT;
          end
        end

        COLLECT: begin
          if (key_edge) begin
            code_out  <= key_code_in;
            valid_out <= 1'b1;
            if (kidx == 3'd4) begin
              kidx   <= 3'd0;
              vtimer <= VT_W'(VERDICT_CYCLES - 1);
              state  <= VERDICT;
            end else begin
              kidx <= kidx + 3'd1;
            end
          end
        end

        VERDICT: begin
          // Keys are dropped here; a flag on the expiry cycle still wins.
          if (dec_any) begin
            fail_cnt <= 3'd0;
            state    <= IDLE;
          end else if (vtimer == '0) begin
            if (fail_next == 3'(MAX_FAIL)) begin
              fail_cnt <= 3'(MAX_FAIL);
              ltimer   <= LT_W'(LOCKOUT_CYCLES - 1);
              lockout  <= 1'b1;
              alarm    <= 1'b1;
              state    <= LOCKOUT;
            end else begin
              fail_cnt <= fail_next;
              state    <= IDLE;
            end
          end else begin
            vtimer <= vtimer - VT_W'(1);
          end
        end

        LOCKOUT: begin
          // Keys are dropped, including one arriving on the exit cycle.
          if (ltimer == '0) begin
            fail_cnt <= 3'd0;
            lockout  <= 1'b0;
            alarm    <= 1'b0;
            state    <= IDLE;
          end else begin
            ltimer <= ltimer - LT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOCK_GUARD_AUTO_RELOCK_EN
  localparam int RH_W = $clog2(RELOCK_CYCLES + 1);

  logic [RH_W-1:0] hold_cnt;

  // Count consecutive OPEN cycles and request a relock every RELOCK_CYCLES.
  always_ff @(posedge clk) begin
    if (!reset_1) begin
      hold_cnt   <= '0;
      relock_req <= 1'b0;
    end else if (dec_open) begin
      if (hold_cnt == RH_W'(RELOCK_CYCLES - 1)) begin
        hold_cnt   <= '0;
        relock_req <= 1'b1;
      end else begin
        hold_cnt   <= hold_cnt + RH_W'(1);
        relock_req <= 1'b0;
      end
    end else begin
      hold_cnt   <= '0;
      relock_req <= 1'b0;
    end
  end
`else
  assign relock_req = 1'b0;
`endif

endmodule

// File: tb/tb_lock_guard.sv
// tb_lock_guard: scoreboard bench for lock_guard. A reference model that
// tracks entries, windows and lockout as absolute deadlines pushes every
// expected forwarded code into a queue; a negedge monitor pops and compares
// whenever valid_out is expected and also compares the status outputs.
module tb_lock_guard;

  localparam int MAX_FAIL       = 3;
  localparam int VERDICT_CYCLES = 4;
  localparam int LOCKOUT_CYCLES = 1000;
`ifdef LOCK_GUARD_AUTO_RELOCK_EN
  localparam int RELOCK_CYCLES  = 10;
`else
  localparam int RELOCK_CYCLES  = 5000;
`endif

  logic       clk = 1'b0;
  logic       reset_1;
  logic [3:0] key_code_in;
  logic       key_valid_in;
  logic       dec_open;
  logic       dec_save;
  logic       dec_change;
  logic [3:0] code_out;
  logic       valid_out;
  logic       lockout;
  logic       alarm;
  logic [2:0] fail_cnt;
  logic       relock_req;

  always #5 clk = ~clk;

  lock_guard #(
    .MAX_FAIL      (MAX_FAIL),
    .VERDICT_CYCLES(VERDICT_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .RELOCK_CYCLES (RELOCK_CYCLES)
  ) dut (
    .clk         (clk),
    .reset_1     (reset_1),
    .key_code_in (key_code_in),
    .key_valid_in(key_valid_in),
    .dec_open    (dec_open),
    .dec_save    (dec_save),
    .dec_change  (dec_change),
    .code_out    (code_out),
    .valid_out   (valid_out),
    .lockout     (lockout),
    .alarm       (alarm),
    .fail_cnt    (fail_cnt),
    .relock_req  (relock_req)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Deadlines are absolute edge numbers: a window opened by the 5th key at
  // edge k closes at edge k+VERDICT_CYCLES; a lockout entered at edge e ends
  // at edge e+LOCKOUT_CYCLES. Zero means "not active".
  int         m_n     = 0;
  bit         m_prev  = 1'b0;
  bit         m_edge;
  int         m_keys  = 0;
  int         m_vend  = 0;
  int         m_lend  = 0;
  int         m_fails = 0;
  logic [3:0] m_code  = 4'd0;
  bit         m_relock = 1'b0;
  int         m_hold  = 0;
  logic [3:0] exp_q[$];

  always @(posedge clk) begin
    m_n++;
    m_relock = 1'b0;
    if (!reset_1) begin
      m_prev  = 1'b0;
      m_keys  = 0;
      m_vend  = 0;
      m_lend  = 0;
      m_fails = 0;
      m_code  = 4'd0;
      m_hold  = 0;
      exp_q.delete();
    end else begin
      m_edge = key_valid_in && !m_prev;
      if (m_lend != 0) begin
        if (m_n == m_lend) begin
          m_fails = 0;
          m_lend  = 0;
        end
      end else if (m_vend != 0) begin
        if (dec_open || dec_save || dec_change) begin
          m_fails = 0;
          m_vend  = 0;
        end else if (m_n == m_vend) begin
          m_vend = 0;
          m_fails++;
          if (m_fails == MAX_FAIL) m_lend = m_n + LOCKOUT_CYCLES;
        end
      end else if (m_edge) begin
        m_code = key_code_in;
        exp_q.push_back(key_code_in);
        m_keys++;
        if (m_keys == 5) begin
          m_keys = 0;
          m_vend = m_n + VERDICT_CYCLES;
        end
      end
`ifdef LOCK_GUARD_AUTO_RELOCK_EN
      if (dec_open) begin
        m_hold++;
        if (m_hold == RELOCK_CYCLES) begin
          m_relock = 1'b1;
          m_hold   = 0;
        end
      end else begin
        m_hold = 0;
      end
`endif
      m_prev = key_valid_in;
    end
  end

  // ---------------- monitor ----------------
  bit mon_en   = 1'b0;
  int n_fwd    = 0;
  int n_relock = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out === 1'b1) n_fwd++;
      if (relock_req === 1'b1) n_relock++;
      if (exp_q.size() > 0) begin
        check("valid_out", valid_out, 1);
        check("fwd_code", code_out, exp_q.pop_front());
      end else begin
        check("valid_out", valid_out, 0);
      end
      check("code_out_hold", code_out, m_code);
      check("lockout", lockout, (m_lend != 0));
      check("alarm", alarm, (m_lend != 0));
      check("fail_cnt", fail_cnt, m_fails);
      check("relock_req", relock_req, m_relock);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] c, input int hold, input int gap);
    key_code_in  = c;
    key_valid_in = 1'b1;
    tick(hold);
    key_valid_in = 1'b0;
    tick(gap);
  endtask

  // Five keys; the 5th is a single-cycle press so the window timing is known.
  task automatic entry(input int last_gap);
    for (int i = 0; i < 4; i++)
      press(4'($urandom_range(0, 11)), $urandom_range(1, 3), $urandom_range(1, 3));
    press(4'($urandom_range(0, 11)), 1, last_gap);
  endtask

  task automatic wait_lockout(input string name);
    int w;
    w = 0;
    while (lockout !== 1'b1 && w < 40) begin
      tick(1);
      w++;
    end
    check(name, lockout, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int r0;
    int cnt;
    int r;

    reset_1      = 1'b0;
    key_code_in  = 4'd0;
    key_valid_in = 1'b0;
    dec_open     = 1'b0;
    dec_save     = 1'b0;
    dec_change   = 1'b0;
    tick(1);
    mon_en = 1'b1;
    tick(2);

    // Reset state.
    check("rst_code_out", code_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_lockout", lockout, 0);
    check("rst_alarm", alarm, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_relock_req", relock_req, 0);
    reset_1 = 1'b1;
    tick(2);

    // Pass-through: 2,4,3,2,# then dec_open two cycles after the 5th key.
    f0 = n_fwd;
    press(4'd2, 1, 1);
    press(4'd4, 2, 1);
    press(4'd3, 1, 2);
    press(4'd2, 1, 1);
    press(4'hA, 1, 0);
    tick(1);
    dec_open = 1'b1;
    tick(1);
    dec_open = 1'b0;
    tick(2);
    check("pass_pulses", n_fwd - f0, 5);
    check("pass_code_out", code_out, 4'hA);
    check("pass_fail_cnt", fail_cnt, 0);
    check("pass_lockout", lockout, 0);

    // Auto-relock: dec_open held 25 cycles outside any window.
    r0 = n_relock;
    dec_open = 1'b1;
    tick(25);
    dec_open = 1'b0;
    tick(2);
`ifdef LOCK_GUARD_AUTO_RELOCK_EN
    check("relock_pulses", n_relock - r0, 2);
`else
    check("relock_pulses", n_relock - r0, 0);
`endif

    // Lockout: three unanswered entries, keys pressed inside the window.
    entry(2);
    tick(8);
    check("fail_after_1", fail_cnt, 1);
    entry(2);
    tick(8);
    check("fail_after_2", fail_cnt, 2);
    f0 = n_fwd;
    entry(1);
    press(4'd5, 1, 1);
    wait_lockout("lockout_entered");
    check("lock_alarm", alarm, 1);
    check("lock_fail_cnt", fail_cnt, MAX_FAIL);
    check("window_key_swallowed", n_fwd - f0, 5);

    // Count lockout cycles; poke keys and hold one across the exit.
    f0 = n_fwd;
    cnt = 0;
    while (lockout === 1'b1 && cnt < LOCKOUT_CYCLES + 50) begin
      key_valid_in = ((cnt % 40) == 10) || (cnt >= LOCKOUT_CYCLES - 10);
      key_code_in  = 4'($urandom_range(0, 11));
      tick(1);
      cnt++;
    end
    check("lockout_len", cnt, LOCKOUT_CYCLES);
    check("exit_fail_cnt", fail_cnt, 0);
    check("exit_alarm", alarm, 0);
    tick(5);
    check("swallow_pulses", n_fwd - f0, 0);
    key_valid_in = 1'b0;
    tick(1);
    press(4'd7, 1, 1);
    check("first_after_exit", code_out, 7);
    check("first_after_exit_cnt", n_fwd - f0, 1);
    // Finish that entry, answered, so the next test starts clean.
    for (int i = 0; i < 4; i++) press(4'd1, 1, 1);
    dec_change = 1'b1;
    tick(1);
    dec_change = 1'b0;
    tick(3);

    // Window boundaries.
    entry(2);
    tick(8);
    check("win_pre_fail", fail_cnt, 1);
    entry(0);
    tick(VERDICT_CYCLES - 1);
    dec_save = 1'b1;
    tick(1);
    dec_save = 1'b0;
    tick(2);
    check("win_edge_success", fail_cnt, 0);
    entry(0);
    tick(VERDICT_CYCLES);
    dec_save = 1'b1;
    tick(1);
    dec_save = 1'b0;
    tick(2);
    check("win_late_fail", fail_cnt, 1);

    // Reset abort mid-lockout.
    entry(2);
    tick(8);
    entry(2);
    wait_lockout("lockout_entered_2");
    tick(LOCKOUT_CYCLES / 2);
    reset_1 = 1'b0;
    tick(1);
    reset_1 = 1'b1;
    check("abort_lockout", lockout, 0);
    check("abort_alarm", alarm, 0);
    check("abort_fail_cnt", fail_cnt, 0);
    check("abort_code_out", code_out, 0);
    f0 = n_fwd;
    entry(2);
    check("abort_entry_fwd", n_fwd - f0, 5);
    tick(8);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 19);
      if (r < 12) begin
        press(4'($urandom_range(0, 11)), $urandom_range(1, 3), $urandom_range(1, 3));
      end else if (r < 19) begin
        case ($urandom_range(0, 3))
          0: dec_open = 1'b1;
          1: dec_save = 1'b1;
          2: dec_change = 1'b1;
          default: ;
        endcase
        tick(1);
        dec_open   = 1'b0;
        dec_save   = 1'b0;
        dec_change = 1'b0;
        tick($urandom_range(0, 6));
      end else begin
        reset_1 = 1'b0;
        tick(1);
        reset_1 = 1'b1;
        tick(1);
      end
    end

    key_valid_in = 1'b0;
    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
